fast_spi_rx_frame_builder: RTL and testbench

Downstream consumer of the fast SPI receiver's 32-bit word FIFO. Each word is {IDENT[3:0], frame[11:0], data[15:0]}. The block pops words, drops words with a foreign identifier, and groups consecutive words with the same frame number. For each completed frame it emits one summary word on a valid/ready stream and keeps bus-readable error and frame statistics.

---
 rtl/fast_spi_rx_frame_builder_if.sv | 37 +++
 rtl/fast_spi_rx_frame_builder.sv | 204 ++++++++++++++++++++
 tb/tb_fast_spi_rx_frame_builder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fast_spi_rx_frame_builder_if.sv
// -----------------------------------------------------------------------------
// fast_spi_rx_frame_builder_if
// Groups the register bus, the upstream FIFO read port and the downstream
// summary stream of fast_spi_rx_frame_builder.
//   master : the side driving the bus, the FIFO head and OUT_READY
//   slave  : the frame builder itself
// Ports:
//   BUS_ADD/BUS_DATA_IN/BUS_WR/BUS_RD  register write/read access
//   BUS_DATA_OUT                       registered read data
//   FIFO_EMPTY/FIFO_DATA/FIFO_READ     first-word-fall-through FIFO port
//   OUT_DATA/OUT_VALID/OUT_READY       frame summary valid/ready stream
// -----------------------------------------------------------------------------
interface fast_spi_rx_frame_builder_if #(
   parameter int ABUSWIDTH = 16
);
   logic [ABUSWIDTH-1:0] BUS_ADD;
   logic [7:0]           BUS_DATA_IN;
   logic [7:0]           BUS_DATA_OUT;
   logic                 BUS_WR;
   logic                 BUS_RD;
   logic                 FIFO_EMPTY;
   logic [31:0]          FIFO_DATA;
   logic                 FIFO_READ;
   logic [31:0]          OUT_DATA;
   logic                 OUT_VALID;
   logic                 OUT_READY;

   modport master (
      output BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD, FIFO_EMPTY, FIFO_DATA, OUT_READY,
      input  BUS_DATA_OUT, FIFO_READ, OUT_DATA, OUT_VALID
   );

   modport slave (
      input  BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD, FIFO_EMPTY, FIFO_DATA, OUT_READY,
      output BUS_DATA_OUT, FIFO_READ, OUT_DATA, OUT_VALID
   );
endinterface

// File: rtl/fast_spi_rx_frame_builder.sv
// -----------------------------------------------------------------------------
// fast_spi_rx_frame_builder
// Pops 32-bit words {IDENT, frame[11:0], data[15:0]} from the SPI receiver
// FIFO, discards words with a foreign identifier, groups consecutive words of
// one frame and emits one summary {IDENT, frame, word_count} per frame.
// Ports:
//   BUS_CLK    single clock
//   BUS_RST_N  asynchronous active-low reset
//   bus        fast_spi_rx_frame_builder_if.slave (register bus, FIFO port,
//              summary stream)
// Registers: 0 version / soft reset, 1 {FLUSH, CONF_EN}, 2 ID_ERR_CNT,
//            3 GAP_CNT, 4/5 FRAME_CNT low/high byte.
// -----------------------------------------------------------------------------
module fast_spi_rx_frame_builder #(
   parameter int         ABUSWIDTH  = 16,
   parameter logic [3:0] IDENTYFIER = 4'b0001,
   parameter logic [7:0] VERSION    = 8'd1
) (
   input logic                      BUS_CLK,
   input logic                      BUS_RST_N,
   fast_spi_rx_frame_builder_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OPEN = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   state_t      state_q;
   logic        conf_en_q;
   logic [11:0] cur_frame_q;
   logic [15:0] word_count_q;
   logic [11:0] last_frame_q;
   logic        have_last_q;
   logic [7:0]  id_err_cnt_q;
   logic [7:0]  gap_cnt_q;
   logic [15:0] frame_cnt_q;
   logic [31:0] out_data_q;
   logic        out_valid_q;
   logic [7:0]  bus_data_out_q;

   logic        soft_rst;
   logic        ctrl_wr;
   logic        flush;
   logic        id_ok;
   logic [11:0] head_frame;
   logic        same_frame;
   logic        pop;
   logic        close;
   logic [15:0] word_count_d;
   logic [7:0]  rd_mux;

   // Saturating 8-bit counter step
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? 8'hFF : v + 8'd1;
   endfunction

   // Saturating 16-bit counter step
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
   endfunction

   assign soft_rst   = bus.BUS_WR && (bus.BUS_ADD == ABUSWIDTH'(0));
   assign ctrl_wr    = bus.BUS_WR && (bus.BUS_ADD == ABUSWIDTH'(1));
   assign flush      = ctrl_wr && bus.BUS_DATA_IN[1];
   assign id_ok      = (bus.FIFO_DATA[31:28] == IDENTYFIER);
   assign head_frame = bus.FIFO_DATA[27:16];
   assign same_frame = (head_frame == cur_frame_q);

   // Pop decision: foreign words are always drained outside EMIT; a valid word
   // of a new frame stays at the head while the open frame is closed.
   always_comb begin
      pop = 1'b0;
      if (!conf_en_q || bus.FIFO_EMPTY) begin
         pop = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: pop = 1'b1;
            ST_OPEN: pop = !id_ok || same_frame;
            ST_EMIT: pop = 1'b0;
            default: pop = 1'b0;
         endcase
      end
   end

   // Frame close condition and the word count including a same-cycle pop
   always_comb begin
      close        = 1'b0;
      word_count_d = word_count_q;
      if (state_q == ST_OPEN) begin
         close = flush || (conf_en_q && !bus.FIFO_EMPTY && id_ok && !same_frame);
         if (pop && id_ok) begin
            word_count_d = sat_inc16(word_count_q);
         end else begin
            word_count_d = word_count_q;
         end
      end else begin
         close        = 1'b0;
         word_count_d = word_count_q;
      end
   end

   // Register read multiplexer
   always_comb begin
      rd_mux = 8'h00;
      case (bus.BUS_ADD)
         ABUSWIDTH'(0): rd_mux = VERSION;
         ABUSWIDTH'(1): rd_mux = {7'b0000000, conf_en_q};
         ABUSWIDTH'(2): rd_mux = id_err_cnt_q;
         ABUSWIDTH'(3): rd_mux = gap_cnt_q;
         ABUSWIDTH'(4): rd_mux = frame_cnt_q[7:0];
         ABUSWIDTH'(5): rd_mux = frame_cnt_q[15:8];
         default:       rd_mux = 8'h00;
      endcase
   end

   // Frame FSM, configuration and statistics counters
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         state_q      <= ST_IDLE;
         conf_en_q    <= 1'b0;
         cur_frame_q  <= 12'd0;
         word_count_q <= 16'd0;
         last_frame_q <= 12'd0;
         have_last_q  <= 1'b0;
         id_err_cnt_q <= 8'd0;
         gap_cnt_q    <= 8'd0;
         frame_cnt_q  <= 16'd0;
         out_data_q   <= 32'd0;
         out_valid_q  <= 1'b0;
      end else if (soft_rst) begin
         state_q      <= ST_IDLE;
         conf_en_q    <= 1'b0;
         cur_frame_q  <= 12'd0;
         word_count_q <= 16'd0;
         last_frame_q <= 12'd0;
         have_last_q  <= 1'b0;
         id_err_cnt_q <= 8'd0;
         gap_cnt_q    <= 8'd0;
         frame_cnt_q  <= 16'd0;
         out_data_q   <= 32'd0;
         out_valid_q  <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            conf_en_q <= bus.BUS_DATA_IN[0];
         end
         if (pop && !id_ok) begin
            id_err_cnt_q <= sat_inc8(id_err_cnt_q);
         end
         case (state_q)
            ST_IDLE: begin
               if (pop && id_ok) begin
                  cur_frame_q  <= head_frame;
                  word_count_q <= 16'd1;
                  state_q      <= ST_OPEN;
                  // 12-bit wrap makes 4095 -> 0 continuous
                  if (have_last_q && (head_frame != 12'(last_frame_q + 12'd1))) begin
                     gap_cnt_q <= sat_inc8(gap_cnt_q);
                  end
               end
            end
            ST_OPEN: begin
               word_count_q <= word_count_d;
               if (close) begin
                  out_data_q   <= {IDENTYFIER, cur_frame_q, word_count_d};
                  out_valid_q  <= 1'b1;
                  last_frame_q <= cur_frame_q;
                  have_last_q  <= 1'b1;
                  state_q      <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (out_valid_q && bus.OUT_READY) begin
                  out_valid_q <= 1'b0;
                  frame_cnt_q <= frame_cnt_q + 16'd1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   // Registered bus read data; deliberately untouched by the soft reset
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         bus_data_out_q <= 8'h00;
      end else if (bus.BUS_RD) begin
         bus_data_out_q <= rd_mux;
      end else begin
         bus_data_out_q <= bus_data_out_q;
      end
   end

   assign bus.FIFO_READ    = pop;
   assign bus.OUT_DATA     = out_data_q;
   assign bus.OUT_VALID    = out_valid_q;
   assign bus.BUS_DATA_OUT = bus_data_out_q;

endmodule

// File: tb/tb_fast_spi_rx_frame_builder.sv
// -----------------------------------------------------------------------------
// tb_fast_spi_rx_frame_builder
// Directed stimulus with a summary scoreboard: expected summaries are queued
// when stimulus is issued and a monitor compares them at each handshake.
// -----------------------------------------------------------------------------
module tb_fast_spi_rx_frame_builder;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fast_spi_rx_frame_builder_if #(.ABUSWIDTH(16)) bus ();

   fast_spi_rx_frame_builder #(
      .ABUSWIDTH (16),
      .IDENTYFIER(4'b0001),
      .VERSION   (8'd1)
   ) dut (
      .BUS_CLK  (clk),
      .BUS_RST_N(rst_n),
      .bus      (bus)
   );

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] fifo_q[$];
   logic [31:0] exp_q[$];
   logic        rd_s = 1'b0;

   function automatic logic [31:0] w(input logic [3:0] id, input logic [11:0] fr,
                                     input logic [15:0] d);
      return {id, fr, d};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic refresh();
      bus.FIFO_EMPTY = (fifo_q.size() == 0);
      bus.FIFO_DATA  = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
   endtask

   // FIFO model: head refreshed twice per cycle, pop strobe sampled mid-cycle
   initial begin
      bus.FIFO_EMPTY = 1'b1;
      bus.FIFO_DATA  = 32'h0;
      forever begin
         @(posedge clk);
         if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
         #1 refresh();
         @(negedge clk);
         refresh();
         #1 rd_s = bus.FIFO_READ;
      end
   end

   // Scoreboard monitor
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && bus.OUT_VALID && bus.OUT_READY) begin
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("FAIL unexpected_summary: got 0x%08h expected none", bus.OUT_DATA);
            end else begin
               check("summary", bus.OUT_DATA, exp_q.pop_front());
            end
         end
      end
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_wr(input logic [15:0] addr, input logic [7:0] data);
      bus.BUS_ADD     = addr;
      bus.BUS_DATA_IN = data;
      bus.BUS_WR      = 1'b1;
      cycles(1);
      bus.BUS_WR      = 1'b0;
   endtask

   task automatic bus_rd_chk(input string name, input logic [15:0] addr, input logic [7:0] exp);
      bus.BUS_ADD = addr;
      bus.BUS_RD  = 1'b1;
      cycles(1);
      bus.BUS_RD  = 1'b0;
      check(name, 32'(bus.BUS_DATA_OUT), 32'(exp));
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while ((fifo_q.size() != 0 || bus.OUT_VALID || exp_q.size() != 0) && k < 300) begin
         cycles(1);
         k++;
      end
      cycles(2);
      check(name, 32'(k < 300), 32'd1);
   endtask

   task automatic wait_valid(input string name);
      int k = 0;
      while (!bus.OUT_VALID && k < 100) begin
         cycles(1);
         k++;
      end
      check(name, 32'(bus.OUT_VALID), 32'd1);
   endtask

   localparam int NREG = 7;
   logic [15:0] reg_addr[NREG] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd7};
   logic [7:0]  reg_rst [NREG] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

   initial begin
      bus.BUS_ADD     = 16'd0;
      bus.BUS_DATA_IN = 8'd0;
      bus.BUS_WR      = 1'b0;
      bus.BUS_RD      = 1'b0;
      bus.OUT_READY   = 1'b0;
      cycles(3);
      rst_n = 1'b1;
      cycles(1);

      // Reset state
      check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
      check("rst_out_data", bus.OUT_DATA, 32'd0);
      check("rst_fifo_read", 32'(bus.FIFO_READ), 32'd0);
      check("rst_bus_data_out", 32'(bus.BUS_DATA_OUT), 32'd0);
      for (int i = 0; i < NREG; i++) bus_rd_chk("rst_reg", reg_addr[i], reg_rst[i]);

      // Basic frame grouping: 3 x frame 5, then frame 6 opens
      bus_wr(16'd1, 8'h01);
      bus.OUT_READY = 1'b1;
      for (int i = 0; i < 3; i++) fifo_q.push_back(w(4'h1, 12'd5, 16'(i)));
      fifo_q.push_back(w(4'h1, 12'd6, 16'hAAAA));
      exp_q.push_back(32'h1005_0003);
      wait_idle("t1_drain");
      bus_rd_chk("t1_frame_cnt", 16'd4, 8'd1);
      exp_q.push_back(32'h1006_0001);
      bus_wr(16'd1, 8'h03);
      wait_idle("t1_flush6");
      bus_rd_chk("t1_gap_cnt", 16'd3, 8'd0);

      // Soft reset clears statistics; wrap 4095 -> 0 is continuous, 0 -> 2 is a gap
      bus_wr(16'd0, 8'h00);
      bus_rd_chk("t2_srst_frame_cnt", 16'd4, 8'd0);
      bus_rd_chk("t2_srst_conf_en", 16'd1, 8'd0);
      bus_wr(16'd1, 8'h01);
      fifo_q.push_back(w(4'h1, 12'd4095, 16'h1));
      fifo_q.push_back(w(4'h1, 12'd4095, 16'h2));
      fifo_q.push_back(w(4'h1, 12'd0, 16'h3));
      fifo_q.push_back(w(4'h1, 12'd2, 16'h4));
      fifo_q.push_back(w(4'h1, 12'd3, 16'h5));
      exp_q.push_back(32'h1FFF_0002);
      exp_q.push_back(32'h1000_0001);
      exp_q.push_back(32'h1002_0001);
      wait_idle("t2_drain");
      bus_rd_chk("t2_gap_cnt", 16'd3, 8'd1);
      exp_q.push_back(32'h1003_0001);
      bus_wr(16'd1, 8'h03);
      wait_idle("t2_flush3");
      bus_rd_chk("t2_frame_cnt", 16'd4, 8'd4);

      // Foreign identifiers interleaved in frame 7
      fifo_q.push_back(w(4'h1, 12'd7, 16'h10));
      fifo_q.push_back(w(4'h2, 12'd7, 16'h11));
      fifo_q.push_back(w(4'h1, 12'd7, 16'h12));
      fifo_q.push_back(w(4'h2, 12'd9, 16'h13));
      fifo_q.push_back(w(4'h1, 12'd7, 16'h14));
      fifo_q.push_back(w(4'h1, 12'd8, 16'h15));
      exp_q.push_back(32'h1007_0003);
      wait_idle("t3_drain");
      bus_rd_chk("t3_id_err_cnt", 16'd2, 8'd2);
      bus_rd_chk("t3_gap_cnt", 16'd3, 8'd2);

      // Back-pressure: summary held stable, FIFO stalled
      bus.OUT_READY = 1'b0;
      fifo_q.push_back(w(4'h1, 12'd8, 16'h20));
      for (int i = 0; i < 3; i++) fifo_q.push_back(w(4'h1, 12'd10, 16'(16'h30 + i)));
      exp_q.push_back(32'h1008_0002);
      wait_valid("t4_valid_rise");
      for (int i = 0; i < 10; i++) begin
         cycles(1);
         check("t4_hold_valid", 32'(bus.OUT_VALID), 32'd1);
         check("t4_hold_data", bus.OUT_DATA, 32'h1008_0002);
         check("t4_hold_fifo_read", 32'(bus.FIFO_READ), 32'd0);
      end
      check("t4_no_pop", fifo_q.size(), 32'd3);
      bus.OUT_READY = 1'b1;
      wait_idle("t4_release");
      exp_q.push_back(32'h100A_0003);
      bus_wr(16'd1, 8'h03);
      wait_idle("t4_flush10");
      bus_rd_chk("t4_gap_cnt", 16'd3, 8'd3);

      // Flush of frame 9, then a second flush that must not emit
      fifo_q.push_back(w(4'h1, 12'd9, 16'h40));
      fifo_q.push_back(w(4'h1, 12'd9, 16'h41));
      wait_idle("t5_drain");
      exp_q.push_back(32'h1009_0002);
      bus_wr(16'd1, 8'h03);
      wait_idle("t5_flush9");
      bus_wr(16'd1, 8'h03);
      cycles(5);
      check("t5_second_flush", 32'(bus.OUT_VALID), 32'd0);
      bus_rd_chk("t5_frame_cnt_lo", 16'd4, 8'd8);
      bus_rd_chk("t5_frame_cnt_hi", 16'd5, 8'd0);
      bus_rd_chk("t5_id_err_cnt", 16'd2, 8'd2);
      bus_rd_chk("t5_gap_cnt", 16'd3, 8'd4);
      bus_rd_chk("t5_conf_en", 16'd1, 8'd1);

      // Async reset mid-frame drops the open frame
      fifo_q.push_back(w(4'h1, 12'd11, 16'h50));
      cycles(4);
      rst_n = 1'b0;
      cycles(1);
      check("t6_arst_valid", 32'(bus.OUT_VALID), 32'd0);
      check("t6_arst_bus_out", 32'(bus.BUS_DATA_OUT), 32'd0);
      rst_n = 1'b1;
      cycles(1);
      bus_rd_chk("t6_arst_frame_cnt", 16'd4, 8'd0);
      bus_rd_chk("t6_arst_gap_cnt", 16'd3, 8'd0);
      bus_rd_chk("t6_arst_id_err", 16'd2, 8'd0);
      bus_rd_chk("t6_arst_conf_en", 16'd1, 8'd0);

      // Soft reset during EMIT: summary dropped, BUS_DATA_OUT retained
      bus_wr(16'd1, 8'h01);
      bus.OUT_READY = 1'b0;
      fifo_q.push_back(w(4'h1, 12'd12, 16'h60));
      fifo_q.push_back(w(4'h1, 12'd13, 16'h61));
      wait_valid("t6_emit");
      bus_rd_chk("t6_version", 16'd0, 8'd1);
      bus_wr(16'd0, 8'h00);
      check("t6_srst_valid", 32'(bus.OUT_VALID), 32'd0);
      check("t6_srst_data", bus.OUT_DATA, 32'd0);
      check("t6_srst_fifo_read", 32'(bus.FIFO_READ), 32'd0);
      check("t6_srst_bus_out_kept", 32'(bus.BUS_DATA_OUT), 32'd1);
      bus.OUT_READY = 1'b1;
      cycles(5);
      check("t6_no_summary_valid", 32'(bus.OUT_VALID), 32'd0);
      check("t6_word_kept", fifo_q.size(), 32'd1);
      bus_rd_chk("t6_srst_frame_cnt", 16'd4, 8'd0);
      check("end_scoreboard_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
